// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Pipeline IF stage with PC, IF/ID register, stall hold buffer and
//            branch redirect handling against a ready/valid instruction memory.
// Revision : 1.0
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcWrite,
    input  logic        ifIdWrite,
    input  logic        branch,
    input  logic [31:0] branchProgramCounter,
    output logic [31:0] imemAddress,
    output logic        imemRequest,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] programCounterOut,
    output logic [31:0] instruction,
    output logic        instructionValid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic [31:0] redirect_pc;

    logic        stall;
    logic        transfer;
    logic [31:0] pc_plus4;

    assign stall       = !pcWrite || !ifIdWrite;
    // Gated by reset so the request drops the instant reset is asserted.
    assign imemRequest = !reset && (state != HOLD);
    assign transfer    = imemRequest && imemReady;
    assign imemAddress = pc;
    assign pc_plus4    = pc + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= FETCH;
            pc                <= RESET_VECTOR;
            hold_buf          <= 32'd0;
            redirect_pc       <= 32'd0;
            programCounterOut <= 32'd0;
            instruction       <= NOP_WORD;
            instructionValid  <= 1'b0;
        end else begin
            // Branch outranks stall in every state and always injects a bubble.
            if (branch) begin
                programCounterOut <= branchProgramCounter;
                instruction       <= NOP_WORD;
                instructionValid  <= 1'b0;
            end

            case (state)
                FETCH: begin
                    if (branch) begin
                        if (transfer) begin
                            pc <= branchProgramCounter;
                        end else begin
                            redirect_pc <= branchProgramCounter;
                            state       <= DISCARD;
                        end
                    end else if (stall) begin
                        if (transfer) begin
                            hold_buf <= imemData;
                            state    <= HOLD;
                        end
                    end else if (transfer) begin
                        programCounterOut <= pc_plus4;
                        instruction       <= imemData;
                        instructionValid  <= 1'b1;
                        pc                <= pc_plus4;
                    end else begin
                        programCounterOut <= pc_plus4;
                        instruction       <= NOP_WORD;
                        instructionValid  <= 1'b0;
                    end
                end

                HOLD: begin
                    if (branch) begin
                        pc    <= branchProgramCounter;
                        state <= FETCH;
                    end else if (!stall) begin
                        programCounterOut <= pc_plus4;
                        instruction       <= hold_buf;
                        instructionValid  <= 1'b1;
                        pc                <= pc_plus4;
                        state             <= FETCH;
                    end
                end

                DISCARD: begin
                    // The outstanding fetch belongs to the wrong path; finish it, drop it.
                    if (branch) begin
                        redirect_pc <= branchProgramCounter;
                        if (transfer) begin
                            pc    <= branchProgramCounter;
                            state <= FETCH;
                        end
                    end else begin
                        if (!stall) begin
                            programCounterOut <= pc_plus4;
                            instruction       <= NOP_WORD;
                            instructionValid  <= 1'b0;
                        end
                        if (transfer) begin
                            pc    <= redirect_pc;
                            state <= FETCH;
                        end
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire
